// File: rtl/mult_mac_pipe.sv
// mult_mac_pipe: pipelined WIDTH x WIDTH multiplier with optional accumulation.
// Stage 1 captures operands, stages 2..STAGES-1 carry the extended product,
// stage STAGES is the accumulator, which drives y directly.
//
// Handshake: an input beat transfers when in_valid && in_ready, an output beat
// when out_valid && out_ready. The whole pipe stalls as one unit: it advances
// when the output register is empty or being drained, so in_ready is simply
// that advance term. Nothing moves while advance is low, so y and out_valid
// are stable under backpressure and input changes are ignored.
module mult_mac_pipe #(
   parameter int WIDTH     = 8,
   parameter int STAGES    = 3,
   parameter int ACC_GUARD = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   input  logic                         signed_mode,
   input  logic                         acc_en,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [2*WIDTH+ACC_GUARD-1:0] y
);

   localparam int YW = 2 * WIDTH + ACC_GUARD;
   localparam int NP = STAGES - 2;   // number of product register stages

   logic                 advance;

   // stage 1: operand capture
   logic                 s1_valid;
   logic [WIDTH-1:0]     s1_a;
   logic [WIDTH-1:0]     s1_b;
   logic                 s1_signed;
   logic                 s1_acc_en;

   // product path
   logic [2*WIDTH-1:0]   prod_u;
   logic [2*WIDTH-1:0]   prod_s;
   logic [YW-1:0]        prod_ext;
   logic [YW-1:0]        p_data [NP];
   logic [NP-1:0]        p_valid;
   logic [NP-1:0]        p_acc_en;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Capture operands and their mode bits; a bubble loads in_valid=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_signed <= 1'b0;
         s1_acc_en <= 1'b0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s1_a      <= a;
         s1_b      <= b;
         s1_signed <= signed_mode;
         s1_acc_en <= acc_en;
      end
   end

   // Full-width product; the signed form multiplies sign-extended operands so
   // the low 2*WIDTH bits are the exact two's-complement product, which is
   // then extended to the accumulator width according to its own mode.
   always_comb begin
      prod_u   = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
      prod_s   = {{WIDTH{s1_a[WIDTH-1]}}, s1_a} * {{WIDTH{s1_b[WIDTH-1]}}, s1_b};
      prod_ext = YW'(prod_u);
      if (s1_signed) begin
         prod_ext = YW'($signed(prod_s));
      end
   end

   // Product register chain: stage 2 takes the new product, later ones shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NP; i++) begin
            p_data[i] <= '0;
         end
         p_valid  <= '0;
         p_acc_en <= '0;
      end else if (advance) begin
         p_data[0]   <= prod_ext;
         p_valid[0]  <= s1_valid;
         p_acc_en[0] <= s1_acc_en;
         for (int i = 1; i < NP; i++) begin
            p_data[i]   <= p_data[i-1];
            p_valid[i]  <= p_valid[i-1];
            p_acc_en[i] <= p_acc_en[i-1];
         end
      end
   end

   // Accumulator / output register; bubbles clear out_valid but leave y alone.
   // The add wraps silently at YW bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         y         <= '0;
      end else if (advance) begin
         out_valid <= p_valid[NP-1];
         if (p_valid[NP-1]) begin
            if (p_acc_en[NP-1]) begin
               y <= y + p_data[NP-1];
            end else begin
               y <= p_data[NP-1];
            end
         end
      end
   end

endmodule
